// File: rtl/spike_readout.sv
// Output-layer spike decoder: counts rising edges per neuron over a fixed window,
// then scans the counts to pick a winner and offers it through a valid/ready handshake.
module spike_readout #(
  parameter int N_OUT      = 3,
  parameter int IDX_W      = 2,
  parameter int CNT_W      = 8,
  parameter int WIN_CYCLES = 64,
  parameter int TIME_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_OUT-1:0]  spike_in,
  input  logic              start,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  winner,
  output logic [CNT_W-1:0]  winner_count,
  output logic [TIME_W-1:0] first_time,
  output logic              no_spike
);

  typedef enum logic [1:0] {IDLE, INTEGRATE, DECIDE, VALID} state_e;

  localparam int SCAN_W = $clog2(N_OUT + 1);

  state_e                         state_q, state_d;
  logic [TIME_W-1:0]              time_q, time_d;
  logic [N_OUT-1:0]               prev_q, prev_d;
  logic [N_OUT-1:0]               seen_q, seen_d;
  logic [N_OUT-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_OUT-1:0][TIME_W-1:0]   first_q, first_d;
  logic [SCAN_W-1:0]              scan_q, scan_d;
  logic [IDX_W-1:0]               best_idx_q, best_idx_d;
  logic [CNT_W-1:0]               best_cnt_q, best_cnt_d;
  logic [TIME_W-1:0]              best_first_q, best_first_d;
  logic [IDX_W-1:0]               winner_q, winner_d;
  logic [CNT_W-1:0]               winner_count_q, winner_count_d;
  logic [TIME_W-1:0]              first_time_q, first_time_d;
  logic                           no_spike_q, no_spike_d;

  logic [N_OUT-1:0]  spike_edge;
  logic [CNT_W-1:0]  cur_cnt;
  logic [TIME_W-1:0] cur_first;
  logic              take;

  assign spike_edge = spike_in & ~prev_q;

  // Mux out the neuron currently under the scan pointer.
  always_comb begin
    cur_cnt   = '0;
    cur_first = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (SCAN_W'(i) == scan_q) begin
        cur_cnt   = cnt_q[i];
        cur_first = first_q[i];
      end
    end
  end

  assign take = (cur_cnt > best_cnt_q) ||
                ((cur_cnt == best_cnt_q) && (cur_cnt != '0) && (cur_first < best_first_q));

  always_comb begin
    state_d        = state_q;
    time_d         = time_q;
    prev_d         = prev_q;
    seen_d         = seen_q;
    cnt_d          = cnt_q;
    first_d        = first_q;
    scan_d         = scan_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    best_first_d   = best_first_q;
    winner_d       = winner_q;
    winner_count_d = winner_count_q;
    first_time_d   = first_time_q;
    no_spike_d     = no_spike_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INTEGRATE;
          time_d  = '0;
          prev_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
          first_d = '0;
        end
      end
      INTEGRATE: begin
        prev_d = spike_in;
        for (int unsigned i = 0; i < N_OUT; i++) begin
          if (spike_edge[i]) begin
            if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
            if (!seen_q[i]) begin
              seen_d[i]  = 1'b1;
              first_d[i] = time_q;
            end
          end
        end
        time_d = time_q + 1'b1;
        if (time_q == TIME_W'(WIN_CYCLES - 1)) begin
          state_d      = DECIDE;
          scan_d       = '0;
          best_idx_d   = '0;
          best_cnt_d   = '0;
          best_first_d = '0;
        end
      end
      DECIDE: begin
        // One extra cycle after the last neuron commits the best-so-far to the outputs.
        if (scan_q == SCAN_W'(N_OUT)) begin
          state_d        = VALID;
          winner_d       = best_idx_q;
          winner_count_d = best_cnt_q;
          first_time_d   = best_first_q;
          no_spike_d     = (best_cnt_q == '0);
        end else begin
          if (take) begin
            best_idx_d   = IDX_W'(scan_q);
            best_cnt_d   = cur_cnt;
            best_first_d = cur_first;
          end
          scan_d = scan_q + 1'b1;
        end
      end
      VALID: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      time_q         <= '0;
      prev_q         <= '0;
      seen_q         <= '0;
      cnt_q          <= '0;
      first_q        <= '0;
      scan_q         <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      best_first_q   <= '0;
      winner_q       <= '0;
      winner_count_q <= '0;
      first_time_q   <= '0;
      no_spike_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      time_q         <= time_d;
      prev_q         <= prev_d;
      seen_q         <= seen_d;
      cnt_q          <= cnt_d;
      first_q        <= first_d;
      scan_q         <= scan_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      best_first_q   <= best_first_d;
      winner_q       <= winner_d;
      winner_count_q <= winner_count_d;
      first_time_q   <= first_time_d;
      no_spike_q     <= no_spike_d;
    end
  end

  assign busy         = (state_q == INTEGRATE) || (state_q == DECIDE);
  assign result_valid = (state_q == VALID);
  assign winner       = winner_q;
  assign winner_count = winner_count_q;
  assign first_time   = first_time_q;
  assign no_spike     = no_spike_q;

endmodule

// File: tb/tb_spike_readout.sv
// Bench for spike_readout: directed vector table, handshake/reset sequences and
// random windows checked against an edge-list ranking model.
module tb_spike_readout;

  localparam int N_OUT  = 3;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 2;
  localparam int WIN    = 16;
  localparam int TIME_W = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_OUT-1:0]  spike_in;
  logic              start;
  logic              busy;
  logic              result_valid;
  logic              result_ready;
  logic [IDX_W-1:0]  winner;
  logic [CNT_W-1:0]  winner_count;
  logic [TIME_W-1:0] first_time;
  logic              no_spike;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_readout #(
    .N_OUT(N_OUT), .IDX_W(IDX_W), .CNT_W(CNT_W), .WIN_CYCLES(WIN), .TIME_W(TIME_W)
  ) dut (
    .clk(clk), .reset(reset), .spike_in(spike_in), .start(start), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .winner(winner),
    .winner_count(winner_count), .first_time(first_time), .no_spike(no_spike)
  );

  typedef struct {
    string       name;
    logic [15:0] m0, m1, m2;
    int          w, c, f, ns;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: list rising edges per neuron, saturate, then rank by
  // (count desc, first time asc, index asc) via a single sortable key.
  task automatic model(input logic [2:0][15:0] m, output int w, output int c,
                       output int f, output int ns);
    int best_key;
    int max_cnt;
    best_key = -1;
    max_cnt  = (1 << CNT_W) - 1;
    w = 0; c = 0; f = 0; ns = 1;
    for (int i = 0; i < N_OUT; i++) begin
      int  n;
      int  first;
      int  key;
      bit  prev;
      n = 0; first = -1; prev = 1'b0;
      for (int t = 0; t < WIN; t++) begin
        if (m[i][t] && !prev) begin
          n++;
          if (first < 0) first = t;
        end
        prev = m[i][t];
      end
      if (n > max_cnt) n = max_cnt;
      if (n > 0) begin
        key = n * 10000 + (99 - first) * 10 + (9 - i);
        if (key > best_key) begin
          best_key = key;
          w = i; c = n; f = first; ns = 0;
        end
      end
    end
  endtask

  task automatic run_window(input string name, input logic [2:0][15:0] m,
                            input bit ready_early, input bit noise, input bit poke_start,
                            input int ew, input int ec, input int ef, input int ens);
    int          n;
    bit          stable;
    logic [31:0] sw, sc, sf, sn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, ".busy_on_start"}, busy, 1);
    for (int t = 0; t < WIN; t++) begin
      spike_in = {m[2][t], m[1][t], m[0][t]};
      if (poke_start && t == 7) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    spike_in     = noise ? 3'($urandom) : '0;
    result_ready = ready_early;
    check({name, ".busy_in_decide"}, busy, 1);
    n = 0;
    while (!result_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (noise) spike_in = 3'($urandom);
    end
    check({name, ".latency"}, n, N_OUT + 1);
    check({name, ".busy_at_valid"}, busy, 0);
    check({name, ".winner"}, winner, ew);
    check({name, ".winner_count"}, winner_count, ec);
    check({name, ".first_time"}, first_time, ef);
    check({name, ".no_spike"}, no_spike, ens);
    if (ready_early) begin
      @(posedge clk); #1;
      check({name, ".one_cycle_valid"}, result_valid, 0);
      check({name, ".idle_after"}, busy, 0);
    end else begin
      stable = 1'b1;
      sw = winner; sc = winner_count; sf = first_time; sn = no_spike;
      for (int k = 0; k < 5; k++) begin
        if (poke_start && k == 2) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (noise) spike_in = 3'($urandom);
        if (!result_valid || busy || winner !== sw[IDX_W-1:0] ||
            winner_count !== sc[CNT_W-1:0] || first_time !== sf[TIME_W-1:0] ||
            no_spike !== sn[0])
          stable = 1'b0;
      end
      check({name, ".hold_stable"}, stable, 1);
      result_ready = 1'b1;
      start        = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      start        = 1'b0;
      check({name, ".valid_drop"}, result_valid, 0);
      @(posedge clk); #1;
      check({name, ".start_at_accept_ignored"}, busy, 0);
      check({name, ".winner_retained"}, winner, ew);
    end
    result_ready = 1'b0;
    spike_in     = '0;
  endtask

  initial begin
    logic [2:0][15:0] m;
    int w, c, f, ns;

    tbl[0] = '{"t1_win1",    16'h0010, 16'h0224, 16'h0000, 1, 3, 2,  0};
    tbl[1] = '{"t2_tie_ft",  16'h0440, 16'h0000, 16'h1008, 2, 2, 3,  0};
    tbl[2] = '{"t2_tie_idx", 16'h0408, 16'h0000, 16'h1008, 0, 2, 3,  0};
    tbl[3] = '{"t3_none",    16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  1};
    tbl[4] = '{"t3_held",    16'hFFFF, 16'h0000, 16'h0000, 0, 1, 0,  0};
    tbl[5] = '{"t4_sat",     16'h5555, 16'h0000, 16'h0000, 0, 3, 0,  0};
    tbl[6] = '{"t4_simul",   16'h0001, 16'h0001, 16'h0001, 0, 1, 0,  0};
    tbl[7] = '{"cnt_beats",  16'h0001, 16'h0000, 16'h1400, 2, 2, 10, 0};
    tbl[8] = '{"last_slot",  16'h0000, 16'h8000, 16'h0000, 1, 1, 15, 0};

    reset = 1'b0; start = 1'b0; result_ready = 1'b0; spike_in = '0;
    #12;
    check("reset.busy", busy, 0);
    check("reset.valid", result_valid, 0);
    check("reset.winner", winner, 0);
    check("reset.count", winner_count, 0);
    check("reset.first", first_time, 0);
    check("reset.no_spike", no_spike, 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_window(tbl[i].name, {tbl[i].m2, tbl[i].m1, tbl[i].m0}, (i % 2) == 1, 1'b0,
                 i == 2, tbl[i].w, tbl[i].c, tbl[i].f, tbl[i].ns);

    // Abort a window part-way through; earlier outputs must clear immediately.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      spike_in = (t % 2 == 0) ? 3'b100 : 3'b000;
      if (t < 8) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b0;
    #2;
    check("abort.busy", busy, 0);
    check("abort.valid", result_valid, 0);
    check("abort.winner", winner, 0);
    check("abort.count", winner_count, 0);
    check("abort.first", first_time, 0);
    check("abort.no_spike", no_spike, 0);
    #2 reset = 1'b1;
    spike_in = '0;
    @(posedge clk); #1;
    check("abort.idle", busy, 0);
    run_window("after_abort", {16'h0000, 16'h0100, 16'h0000}, 1'b0, 1'b0, 1'b0, 1, 1, 8, 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N_OUT; i++)
        m[i] = (r % 2 == 0) ? (16'($urandom) & 16'($urandom)) : 16'($urandom);
      if (r % 5 == 0) m[$urandom_range(0, 2)] = '0;
      model(m, w, c, f, ns);
      run_window($sformatf("rand%0d", r), m, $urandom_range(0, 1) == 1, 1'b1,
                 (r % 3) == 0, w, c, f, ns);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spike_readout.md
Name: spike_readout

Overview:
- Output-side decoder for the spiking network: the counterpart of the input-layer spike encoders.
- Observes the spike lines of the output-layer neurons over one integration window, counts rising edges per neuron and records each neuron's first-spike time.
- Selects the winning neuron and presents the class index with a valid/ready handshake to downstream logic or the testbench.

Parameters:
- N_OUT, 3, number of output neurons observed.
- IDX_W, 2, width of winner index; must satisfy 2^IDX_W >= N_OUT.
- CNT_W, 8, width of per-neuron spike counters.
- WIN_CYCLES, 64, integration window length in clk cycles (>=2).
- TIME_W, 7, width of window time counter; must satisfy 2^TIME_W > WIN_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- spike_in  input  N_OUT  level spike lines from the output neurons; bit i = neuron i.
- start  input  1  one-cycle request to begin a window; honoured only in IDLE.
- busy  output  1  high in INTEGRATE and DECIDE.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.
- winner  output  IDX_W  index of the winning neuron.
- winner_count  output  CNT_W  spike count of the winner.
- first_time  output  TIME_W  window time of the winner's first spike; 0 if none.
- no_spike  output  1  no neuron spiked during the window.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All counters, first-time registers and edge-detect registers clear.
  - Outputs: busy=0, result_valid=0, winner=0, winner_count=0, first_time=0, no_spike=0.
  - Reset mid-window or mid-handshake aborts with no result.
- States are IDLE, INTEGRATE, DECIDE and VALID.
- IDLE:
  - start=1 at edge E0 moves to INTEGRATE.
  - At the same edge: clear all counts, clear prev_spike to 0, clear seen flags, set time to 0.
- INTEGRATE:
  - Runs for exactly WIN_CYCLES cycles, sampling at edges E1..E_WIN_CYCLES.
  - Window time t at edge Ek is k-1 (range 0..WIN_CYCLES-1).
  - Per bit i, edge = spike_in[i] & ~prev_spike[i]; prev_spike updates every INTEGRATE cycle.
  - A line already high at E1 counts as one spike.
  - On an edge, count[i] increments and saturates at 2^CNT_W-1 (no wrap).
  - On the first edge of neuron i, first[i] = t and seen[i] = 1.
  - Simultaneous edges on several bits are all counted in the same cycle.
  - After the edge with t = WIN_CYCLES-1, the state moves to DECIDE.
- DECIDE:
  - Sequential scan, one neuron per cycle, i = 0..N_OUT-1, taking N_OUT cycles.
  - Neuron i replaces the current best if count[i] > best_count.
  - On equal nonzero count, neuron i replaces the best if first[i] < best_first.
  - Any remaining tie keeps the lower index.
  - If all counts are 0: winner=0, winner_count=0, first_time=0, no_spike=1.
  - After the last index, the state moves to VALID.
- Result timing:
  - result_valid rises after edge E(WIN_CYCLES+N_OUT+1) relative to start at E0.
- VALID:
  - result_valid=1.
  - winner, winner_count, first_time and no_spike are held stable until the handshake completes.
  - Handshake completes on an edge with result_valid & result_ready; the state returns to IDLE and result_valid drops.
  - Result outputs retain their last values in IDLE until the next DECIDE overwrites them.
  - result_ready high in advance gives a 1-cycle VALID.
- start handling:
  - start outside IDLE is ignored and not queued.
  - start coinciding with the accepting handshake edge is ignored; a new window needs start while in IDLE.
- Spikes outside INTEGRATE are ignored.

Test Plan:
1. WIN_CYCLES=16, N_OUT=3. Start; neuron 1 pulses at t=2,5,9 and neuron 0 pulses at t=4 -> after 16+3+1 cycles: winner=1, winner_count=3, first_time=2, no_spike=0.
2. Tie: neurons 0 and 2 both get 2 pulses, first at t=6 and t=3 respectively -> winner=2, winner_count=2, first_time=3. Same first time on both -> winner=0.
3. No spikes in window -> result_valid with no_spike=1, winner=0, winner_count=0, first_time=0. spike_in[0] held high for the whole window -> count 1, first_time=0.
4. CNT_W=2, neuron 0 toggling every 2 cycles for 16 cycles -> winner_count saturates at 3. Simultaneous edges on all bits at t=0 -> each count=1, winner=0.
5. result_ready low for 5 cycles -> outputs stable and result_valid held throughout. start pulsed during INTEGRATE and during VALID -> ignored; busy profile unchanged.
6. reset asserted at t=8 of a window -> immediate IDLE with all outputs 0. A new start after release produces a clean result uncontaminated by earlier counts.
